multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//  Sequencer for the multicycle RV32I datapath: one shared memory, one ALU, instruction/data regs.
//  Decodes op/funct3/funct7 and steps each instruction through FETCH..writeback.
//  Drives all datapath mux selects and write enables; stalls on memory via mem_ready handshake.
//  Supports lw, sw, R-type, I-type ALU, beq/bne, jal; other opcodes are illegal and flagged.
// PARAMETERS
//  (none) -- encodings are fixed constants in the shared package
// PORTS
//  clk          in   1  single clock, all state updates on rising edge
//  rst          in   1  synchronous, active-high reset
//  op           in   7  opcode of instruction register
//  funct3       in   3  instr[14:12]
//  funct7       in   1  instr[30]
//  zero         in   1  ALU zero flag
//  mem_ready    in   1  memory completes current access this cycle
//  pc_write     out  1  PC load enable
//  adr_src      out  1  mem address: 0=PC, 1=ALU result reg
//  mem_write    out  1  memory write request
//  ir_write     out  1  instruction/old-PC register load
//  reg_write    out  1  register file write enable
//  result_src   out  2  00=ALU out reg, 01=data reg, 10=ALU result
//  alu_src_a    out  2  00=PC, 01=old PC, 10=rs1
//  alu_src_b    out  2  00=rs2, 01=imm, 10=const 4
//  imm_src      out  2  00=I, 01=S, 10=B, 11=J
//  alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
//  illegal_op   out  1  one-cycle pulse in DECODE for unsupported opcode
//  state        out  4  current state, debug/verification visibility
// BEHAVIOUR
//  Reset: rst=1 at edge -> state=FETCH. Outputs combinational from state; while rst=1 all
//   enables (pc_write, mem_write, ir_write, reg_write, illegal_op) forced 0, selects 0; rst
//   mid-instruction abandons it, no partial writes after the reset edge.
//  Per-state outputs (unlisted = 0); alu_op 00=add, 01=sub, 10=funct decode:
//   FETCH    adr_src0 a00 b10 op00 res10; ir_write=pc_write=mem_ready; stay until mem_ready
//   DECODE   a01 b01 op00 (branch target); -> MEMADR(lw/sw) EXECR EXECI BRANCH JAL, else FETCH+illegal_op
//   MEMADR   a10 b01 op00; -> MEMREAD(lw) / MEMWRITE(sw)
//   MEMREAD  adr_src1 res00; stay until mem_ready; -> MEMWB
//   MEMWB    res01 reg_write; -> FETCH
//   MEMWRITE adr_src1 res00 mem_write=1 held until mem_ready; -> FETCH
//   EXECR    a10 b00 op10; -> ALUWB     EXECI a10 b01 op10; -> ALUWB
//   ALUWB    res00 reg_write; -> FETCH
//   BRANCH   a10 b00 op01 res00; pc_write = zero (beq, f3=000) / ~zero (bne, f3=001),
//            other funct3 -> pc_write=0; -> FETCH
//   JAL      a01 b10 op00 res00 pc_write=1; -> ALUWB (rd=PC+4)
//  Latency with mem_ready=1: lw 5, sw 4, R/I 4, branch 3, jal 4 cycles; each mem wait adds 1.
//  mem_ready sampled only in FETCH/MEMREAD/MEMWRITE; ignored elsewhere.
//  ALU decode (alu_op=10): f3 000 -> sub if op[5]&funct7 else add; 010 slt; 110 or; 111 and;
//   other funct3 -> add. alu_op 00 -> add, 01 -> sub.
//  imm_src from op only: lw/I-ALU 00, sw 01, branch 10, jal 11, else 00.
//  Opcodes: lw 0000011, sw 0100011, R 0110011, I 0010011, branch 1100011, jal 1101111.
//  Unused state encodings -> FETCH next cycle, all enables 0.
// STRUCTURE
//  Shared package riscv_mc_pkg: state encodings, opcode constants, alu_control and
//   select encodings.
//  One sub-module mc_alu_decoder (combinational alu_op/funct -> alu_control); FSM in top.
// TESTING
//  lw (op 0000011), mem_ready=1 -> states F,D,MA,MR,WB; reg_write only in WB, res=01.
//  sw, mem_ready low 3 cycles in MEMWRITE -> mem_write held 4 cycles, adr_src=1, no reg_write.
//  R sub (f3 000, funct7=1) -> alu_control=001 in EXECR; with funct7=0 -> 000; slt -> 101.
//  beq zero=1 -> pc_write=1 in BRANCH; zero=0 -> 0; bne inverts; 3 cycles each.
//  jal -> pc_write=1 in JAL, reg_write=1 in ALUWB, imm_src=11; op 1111111 -> illegal_op pulse, FETCH.
//  rst asserted in MEMREAD -> next cycle FETCH, no reg_write; FETCH with mem_ready=0 -> no ir/pc write.

Source files
------------

// File: rtl/riscv_mc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_mc_pkg
// Description : Shared encodings for the multicycle RV32I control path.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_mc_pkg;

  typedef logic [3:0] state_t;

  localparam state_t c_st_fetch    = 4'd0;
  localparam state_t c_st_decode   = 4'd1;
  localparam state_t c_st_memadr   = 4'd2;
  localparam state_t c_st_memread  = 4'd3;
  localparam state_t c_st_memwb    = 4'd4;
  localparam state_t c_st_memwrite = 4'd5;
  localparam state_t c_st_execr    = 4'd6;
  localparam state_t c_st_execi    = 4'd7;
  localparam state_t c_st_aluwb    = 4'd8;
  localparam state_t c_st_branch   = 4'd9;
  localparam state_t c_st_jal      = 4'd10;

  localparam logic [6:0] c_op_lw     = 7'b0000011;
  localparam logic [6:0] c_op_sw     = 7'b0100011;
  localparam logic [6:0] c_op_rtype  = 7'b0110011;
  localparam logic [6:0] c_op_itype  = 7'b0010011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_jal    = 7'b1101111;

  localparam logic [2:0] c_alu_add = 3'b000;
  localparam logic [2:0] c_alu_sub = 3'b001;
  localparam logic [2:0] c_alu_and = 3'b010;
  localparam logic [2:0] c_alu_or  = 3'b011;
  localparam logic [2:0] c_alu_slt = 3'b101;

  localparam logic [1:0] c_aluop_add   = 2'b00;
  localparam logic [1:0] c_aluop_sub   = 2'b01;
  localparam logic [1:0] c_aluop_funct = 2'b10;

  localparam logic [1:0] c_res_aluout = 2'b00;
  localparam logic [1:0] c_res_data   = 2'b01;
  localparam logic [1:0] c_res_alu    = 2'b10;

  localparam logic [1:0] c_a_pc    = 2'b00;
  localparam logic [1:0] c_a_oldpc = 2'b01;
  localparam logic [1:0] c_a_rs1   = 2'b10;

  localparam logic [1:0] c_b_rs2  = 2'b00;
  localparam logic [1:0] c_b_imm  = 2'b01;
  localparam logic [1:0] c_b_four = 2'b10;

  localparam logic [1:0] c_imm_i = 2'b00;
  localparam logic [1:0] c_imm_s = 2'b01;
  localparam logic [1:0] c_imm_b = 2'b10;
  localparam logic [1:0] c_imm_j = 2'b11;

  function automatic logic [1:0] imm_src_of(input logic [6:0] i_op);
    case (i_op)
      c_op_sw:     imm_src_of = c_imm_s;
      c_op_branch: imm_src_of = c_imm_b;
      c_op_jal:    imm_src_of = c_imm_j;
      default:     imm_src_of = c_imm_i;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_alu_decoder.sv
`default_nettype none
// ============================================================================
// Module      : mc_alu_decoder
// Description : Maps alu_op plus instruction function fields to alu_control.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_alu_decoder
  import riscv_mc_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic       i_op5,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7,
  output logic [2:0] o_alu_control
);

  always_comb begin
    o_alu_control = c_alu_add;
    case (i_alu_op)
      c_aluop_sub: o_alu_control = c_alu_sub;
      c_aluop_funct: begin
        case (i_funct3)
          // op[5] separates R-type sub from I-type addi (which has no sub form)
          3'b000:  o_alu_control = (i_op5 & i_funct7) ? c_alu_sub : c_alu_add;
          3'b010:  o_alu_control = c_alu_slt;
          3'b110:  o_alu_control = c_alu_or;
          3'b111:  o_alu_control = c_alu_and;
          default: o_alu_control = c_alu_add;
        endcase
      end
      default: o_alu_control = c_alu_add;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_fsm
// Description : Instruction sequencer and datapath control for multicycle RV32I.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_fsm
  import riscv_mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t     r_state;
  state_t     w_state_next;
  logic [1:0] w_alu_op;

  always_ff @(posedge clk) begin
    if (rst) r_state <= c_st_fetch;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = c_st_fetch;
    case (r_state)
      c_st_fetch:    w_state_next = mem_ready ? c_st_decode : c_st_fetch;
      c_st_decode: begin
        case (op)
          c_op_lw, c_op_sw: w_state_next = c_st_memadr;
          c_op_rtype:       w_state_next = c_st_execr;
          c_op_itype:       w_state_next = c_st_execi;
          c_op_branch:      w_state_next = c_st_branch;
          c_op_jal:         w_state_next = c_st_jal;
          default:          w_state_next = c_st_fetch;
        endcase
      end
      c_st_memadr:   w_state_next = (op == c_op_lw) ? c_st_memread : c_st_memwrite;
      c_st_memread:  w_state_next = mem_ready ? c_st_memwb : c_st_memread;
      c_st_memwrite: w_state_next = mem_ready ? c_st_fetch : c_st_memwrite;
      c_st_execr,
      c_st_execi,
      c_st_jal:      w_state_next = c_st_aluwb;
      default:       w_state_next = c_st_fetch;
    endcase
  end

  always_comb begin
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = c_res_aluout;
    alu_src_a  = c_a_pc;
    alu_src_b  = c_b_rs2;
    w_alu_op   = c_aluop_add;
    illegal_op = 1'b0;
    imm_src    = imm_src_of(op);
    case (r_state)
      c_st_fetch: begin
        alu_src_b  = c_b_four;
        result_src = c_res_alu;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      c_st_decode: begin
        alu_src_a  = c_a_oldpc;
        alu_src_b  = c_b_imm;
        illegal_op = (w_state_next == c_st_fetch);
      end
      c_st_memadr: begin
        alu_src_a = c_a_rs1;
        alu_src_b = c_b_imm;
      end
      c_st_memread:  adr_src = 1'b1;
      c_st_memwb: begin
        result_src = c_res_data;
        reg_write  = 1'b1;
      end
      c_st_memwrite: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      c_st_execr: begin
        alu_src_a = c_a_rs1;
        w_alu_op  = c_aluop_funct;
      end
      c_st_execi: begin
        alu_src_a = c_a_rs1;
        alu_src_b = c_b_imm;
        w_alu_op  = c_aluop_funct;
      end
      c_st_aluwb:    reg_write = 1'b1;
      c_st_branch: begin
        alu_src_a = c_a_rs1;
        w_alu_op  = c_aluop_sub;
        case (funct3)
          3'b000:  pc_write = zero;
          3'b001:  pc_write = ~zero;
          default: pc_write = 1'b0;
        endcase
      end
      c_st_jal: begin
        alu_src_a = c_a_oldpc;
        alu_src_b = c_b_four;
        pc_write  = 1'b1;
      end
      default: imm_src = c_imm_i;
    endcase
    // Reset overrides everything so an abandoned instruction cannot write anything
    if (rst) begin
      pc_write   = 1'b0;
      adr_src    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      result_src = 2'b00;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      imm_src    = 2'b00;
      w_alu_op   = c_aluop_add;
      illegal_op = 1'b0;
    end
  end

  mc_alu_decoder u_alu_decoder (
    .i_alu_op      (w_alu_op),
    .i_op5         (op[5]),
    .i_funct3      (funct3),
    .i_funct7      (funct7),
    .o_alu_control (alu_control)
  );

  assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control_fsm
// Description : Randomized self-checking bench against an instruction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_fsm;
  import riscv_mc_pkg::*;

  localparam logic [2:0] A_ADD = 3'b000, A_SUB = 3'b001, A_AND = 3'b010,
                         A_OR  = 3'b011, A_SLT = 3'b101;
  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                         OP_I  = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;

  typedef struct packed {
    logic       pc_write, adr_src, mem_write, ir_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;
    logic       illegal_op;
    logic [3:0] state;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, funct7, zero, mem_ready;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic [3:0] state;

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t q_exp[$];
  vec_t q_obs[$];
  logic q_mr[$];
  logic [6:0] m_op;
  logic [2:0] m_f3;
  logic       m_f7, m_z;

  multicycle_control_fsm dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
    .alu_control(alu_control), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  function automatic vec_t observe();
    vec_t v;
    v = '{pc_write, adr_src, mem_write, ir_write, reg_write, result_src, alu_src_a,
          alu_src_b, imm_src, alu_control, illegal_op, state};
    return v;
  endfunction

  function automatic logic [1:0] imm_ref(input logic [6:0] o);
    if (o == OP_SW) return 2'b01;
    if (o == OP_BR) return 2'b10;
    if (o == OP_JAL) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [2:0] alu_ref(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (o[5] && f7) ? A_SUB : A_ADD;
      3'b010:  return A_SLT;
      3'b110:  return A_OR;
      3'b111:  return A_AND;
      default: return A_ADD;
    endcase
  endfunction

  task automatic push(input logic mr, input logic pcw, adr, mw, irw, rw, ill,
                      input logic [1:0] res, a, b, input logic [2:0] ac, input logic [3:0] st);
    vec_t v;
    v = '{pcw, adr, mw, irw, rw, res, a, b, imm_ref(m_op), ac, ill, st};
    q_mr.push_back(mr);
    q_exp.push_back(v);
  endtask

  // Instruction-level model: expected cycle list for one instruction, with
  // wf fetch stalls and wm data-memory stalls; mem_ready is random where ignored.
  task automatic build(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input logic z, input int wf, input int wm);
    logic legal;
    logic pb;
    q_exp.delete(); q_mr.delete();
    m_op = o; m_f3 = f3; m_f7 = f7; m_z = z;
    legal = o inside {OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL};
    for (int i = 0; i < wf; i++) push(0, 0,0,0,0,0,0, 2'b10,2'b00,2'b10, A_ADD, c_st_fetch);
    push(1, 1,0,0,1,0,0, 2'b10,2'b00,2'b10, A_ADD, c_st_fetch);
    push(1'($urandom_range(0,1)), 0,0,0,0,0,!legal, 2'b00,2'b01,2'b01, A_ADD, c_st_decode);
    case (o)
      OP_LW: begin
        push(1'($urandom_range(0,1)), 0,0,0,0,0,0, 2'b00,2'b10,2'b01, A_ADD, c_st_memadr);
        for (int i = 0; i <= wm; i++)
          push(i == wm, 0,1,0,0,0,0, 2'b00,2'b00,2'b00, A_ADD, c_st_memread);
        push(1'($urandom_range(0,1)), 0,0,0,0,1,0, 2'b01,2'b00,2'b00, A_ADD, c_st_memwb);
      end
      OP_SW: begin
        push(1'($urandom_range(0,1)), 0,0,0,0,0,0, 2'b00,2'b10,2'b01, A_ADD, c_st_memadr);
        for (int i = 0; i <= wm; i++)
          push(i == wm, 0,1,1,0,0,0, 2'b00,2'b00,2'b00, A_ADD, c_st_memwrite);
      end
      OP_R, OP_I: begin
        push(1'($urandom_range(0,1)), 0,0,0,0,0,0, 2'b00,2'b10, (o == OP_I) ? 2'b01 : 2'b00,
             alu_ref(o, f3, f7), (o == OP_I) ? c_st_execi : c_st_execr);
        push(1'($urandom_range(0,1)), 0,0,0,0,1,0, 2'b00,2'b00,2'b00, A_ADD, c_st_aluwb);
      end
      OP_BR: begin
        pb = (f3 == 3'b000) ? z : (f3 == 3'b001) ? !z : 1'b0;
        push(1'($urandom_range(0,1)), pb,0,0,0,0,0, 2'b00,2'b10,2'b00, A_SUB, c_st_branch);
      end
      OP_JAL: begin
        push(1'($urandom_range(0,1)), 1,0,0,0,0,0, 2'b00,2'b01,2'b10, A_ADD, c_st_jal);
        push(1'($urandom_range(0,1)), 0,0,0,0,1,0, 2'b00,2'b00,2'b00, A_ADD, c_st_aluwb);
      end
      default: ;
    endcase
  endtask

  // Applies the first n modelled cycles and records the outputs (no checking here).
  task automatic drive(input int n);
    q_obs.delete();
    for (int i = 0; i < n; i++) begin
      op = m_op; funct3 = m_f3; funct7 = m_f7; zero = m_z; mem_ready = q_mr[i];
      @(negedge clk);
      q_obs.push_back(observe());
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    vec_t want;
    rst = 1'b1; op = OP_JAL; funct3 = 3'b000; funct7 = 1'b0; zero = 1'b1; mem_ready = 1'b1;
    want = '0;
    want.state = c_st_fetch;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++;
      if (observe() !== want) begin
        n_bad++;
        $display("FAIL reset cyc%0d: got %h want %h", k, observe(), want);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_lw();
    int rw_at;
    build(OP_LW, 3'b010, 1'b0, 1'b0, 0, 0);
    drive(q_exp.size());
    rw_at = -1;
    foreach (q_exp[i]) begin
      n_cmp++;
      if (q_obs[i] !== q_exp[i]) begin n_bad++; $display("FAIL lw cyc%0d: got %h want %h", i, q_obs[i], q_exp[i]); end
      if (q_obs[i].reg_write) rw_at = i;
    end
    n_cmp++;
    if (rw_at !== 4) begin n_bad++; $display("FAIL lw_regwrite_cycle: got %0d want 4", rw_at); end
  endtask

  task automatic test_sw_wait();
    int n_mw, n_rw;
    build(OP_SW, 3'b010, 1'b0, 1'b0, 1, 3);
    drive(q_exp.size());
    n_mw = 0; n_rw = 0;
    foreach (q_exp[i]) begin
      n_cmp++;
      if (q_obs[i] !== q_exp[i]) begin n_bad++; $display("FAIL sw cyc%0d: got %h want %h", i, q_obs[i], q_exp[i]); end
      n_mw += int'(q_obs[i].mem_write);
      n_rw += int'(q_obs[i].reg_write);
    end
    n_cmp++;
    if (n_mw !== 4 || n_rw !== 0) begin
      n_bad++; $display("FAIL sw_counts: got mw=%0d rw=%0d want mw=4 rw=0", n_mw, n_rw);
    end
  endtask

  task automatic test_alu();
    logic [6:0] ops [6] = '{OP_R, OP_R, OP_R, OP_R, OP_R, OP_I};
    logic [2:0] f3s [6] = '{3'b000, 3'b000, 3'b010, 3'b110, 3'b111, 3'b000};
    logic       f7s [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int t = 0; t < 6; t++) begin
      build(ops[t], f3s[t], f7s[t], 1'b0, 0, 0);
      drive(q_exp.size());
      foreach (q_exp[i]) begin
        n_cmp++;
        if (q_obs[i] !== q_exp[i]) begin n_bad++; $display("FAIL alu%0d cyc%0d: got %h want %h", t, i, q_obs[i], q_exp[i]); end
      end
    end
  endtask

  task automatic test_branch();
    logic [2:0] f3s [6] = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b100, 3'b101};
    logic       zs  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int t = 0; t < 6; t++) begin
      build(OP_BR, f3s[t], 1'b0, zs[t], 0, 0);
      drive(q_exp.size());
      foreach (q_exp[i]) begin
        n_cmp++;
        if (q_obs[i] !== q_exp[i]) begin n_bad++; $display("FAIL branch%0d cyc%0d: got %h want %h", t, i, q_obs[i], q_exp[i]); end
      end
    end
  endtask

  task automatic test_jal_illegal();
    int n_ill;
    build(OP_JAL, 3'b000, 1'b0, 1'b0, 0, 0);
    drive(q_exp.size());
    foreach (q_exp[i]) begin
      n_cmp++;
      if (q_obs[i] !== q_exp[i]) begin n_bad++; $display("FAIL jal cyc%0d: got %h want %h", i, q_obs[i], q_exp[i]); end
    end
    build(7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0);
    drive(q_exp.size());
    n_ill = 0;
    foreach (q_exp[i]) begin
      n_cmp++;
      if (q_obs[i] !== q_exp[i]) begin n_bad++; $display("FAIL illegal cyc%0d: got %h want %h", i, q_obs[i], q_exp[i]); end
      n_ill += int'(q_obs[i].illegal_op);
    end
    n_cmp++;
    if (n_ill !== 1) begin n_bad++; $display("FAIL illegal_pulses: got %0d want 1", n_ill); end
  endtask

  task automatic test_reset_mid();
    vec_t want;
    build(OP_LW, 3'b010, 1'b0, 1'b0, 0, 0);
    drive(3);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (q_obs[i] !== q_exp[i]) begin n_bad++; $display("FAIL rstmid cyc%0d: got %h want %h", i, q_obs[i], q_exp[i]); end
    end
    rst = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    want = '0; want.state = c_st_memread;
    n_cmp++;
    if (observe() !== want) begin n_bad++; $display("FAIL rstmid_hold: got %h want %h", observe(), want); end
    @(posedge clk); #1;
    rst = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    want = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, A_ADD, 1'b0, c_st_fetch};
    n_cmp++;
    if (observe() !== want) begin n_bad++; $display("FAIL fetch_stall: got %h want %h", observe(), want); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [6:0] o;
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 6))
        0: o = OP_LW;  1: o = OP_SW;  2: o = OP_R;  3: o = OP_I;
        4: o = OP_BR;  5: o = OP_JAL;
        default: begin
          o = 7'($urandom);
          while (o inside {OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL}) o = 7'($urandom);
        end
      endcase
      build(o, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 3), $urandom_range(0, 3));
      drive(q_exp.size());
      foreach (q_exp[i]) begin
        n_cmp++;
        if (q_obs[i] !== q_exp[i]) begin
          n_bad++; $display("FAIL rand%0d op=%b cyc%0d: got %h want %h", t, o, i, q_obs[i], q_exp[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_wait();
    test_alu();
    test_branch();
    test_jal_illegal();
    test_reset_mid();
    test_random();
    test_lw();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
